// File: rtl/irq_scheduler_pkg.sv
// Shared types and constants for the i8080 interrupt scheduler.
// The RST opcodes live here so the CPU data-in mux can reuse them.
package irq_scheduler_pkg;

    // Handshake sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Debug view of the scheduler, bound by checkers and the bench
    typedef struct packed {
        state_t state;        // current sequencer state
        logic   inte_blocked; // request is up but the CPU has interrupts masked
        logic   mid_pend;     // RST 1 pending
        logic   vbl_pend;     // RST 2 pending
    } dbg_t;

    localparam logic [7:0] RST1_OP = 8'hCF;
    localparam logic [7:0] RST2_OP = 8'hD7;
    localparam logic [7:0] NOP_OP  = 8'h00;

    localparam int LINE_W       = 9;
    localparam int DEF_LINES    = 262;
    localparam int DEF_MID_LINE = 96;
    localparam int DEF_VBL_LINE = 224;

    // Saturating 8-bit increment used by the overrun counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/irq_scheduler_if.sv
// INT/INTA handshake between the scheduler and the i8080.
//
// Handshake: int_req is the scheduler's "valid"; it holds int_data stable
// while high and keeps it frozen until inta falls. inta is the CPU's "ready"
// and is a level held high for the whole acknowledge fetch. A transfer is
// taken on the first edge where int_req=1 and inta=1; int_req then drops for
// the remainder of the fetch so the CPU cannot take the same vector twice.
// inte reports the CPU's interrupt-enable flip-flop and is advisory only.
interface irq_scheduler_if;
    logic       int_req;
    logic [7:0] int_data;
    logic       inta;
    logic       inte;

    modport master (
        output int_req,
        output int_data,
        input  inta,
        input  inte
    );

    modport slave (
        input  int_req,
        input  int_data,
        output inta,
        output inte
    );
endinterface

// File: rtl/irq_scheduler_scanline_counter.sv
// Scanline counter: advances on each line strobe, wraps at the end of the
// frame and emits one-cycle event pulses when the new line hits the mid-screen
// or vblank line. Pulses are registered, so they appear one edge after the tick.
module scanline_counter
    import irq_scheduler_pkg::*;
#(
    parameter int LINES    = DEF_LINES,
    parameter int MID_LINE = DEF_MID_LINE,
    parameter int VBL_LINE = DEF_VBL_LINE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_tick,
    output logic [LINE_W-1:0] line,
    output logic              mid_evt,
    output logic              vbl_evt
);

    logic [LINE_W-1:0] line_n;

    // Next line value with wrap at LINES-1
    always_comb begin
        line_n = line;
        if (line_tick) begin
            if (line == LINE_W'(LINES - 1)) begin
                line_n = '0;
            end else begin
                line_n = line + LINE_W'(1);
            end
        end
    end

    // Line register and event pulses compared against the new line value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line    <= '0;
            mid_evt <= 1'b0;
            vbl_evt <= 1'b0;
        end else begin
            line    <= line_n;
            mid_evt <= line_tick && (line_n == LINE_W'(MID_LINE));
            vbl_evt <= line_tick && (line_n == LINE_W'(VBL_LINE));
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// Space Invaders interrupt scheduler: turns scanline events into RST 1 / RST 2
// requests for the i8080, sequences INT/INTA and supplies the RST opcode
// during the acknowledge fetch. Pending flags remember one event per vector;
// an event for a vector that is still pending is dropped and counted.
module irq_scheduler
    import irq_scheduler_pkg::*;
#(
    parameter int         LINES    = DEF_LINES,
    parameter int         MID_LINE = DEF_MID_LINE,
    parameter int         VBL_LINE = DEF_VBL_LINE,
    parameter logic [7:0] MID_VEC  = RST1_OP,
    parameter logic [7:0] VBL_VEC  = RST2_OP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_tick,
    input  logic                  irq_en,
    irq_scheduler_if.master       cpu,
    output logic [LINE_W-1:0]     line,
    output logic [7:0]            overrun_cnt,
    output dbg_t                  dbg
);

    logic mid_evt;
    logic vbl_evt;

    scanline_counter #(
        .LINES    (LINES),
        .MID_LINE (MID_LINE),
        .VBL_LINE (VBL_LINE)
    ) u_lines (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_tick (line_tick),
        .line      (line),
        .mid_evt   (mid_evt),
        .vbl_evt   (vbl_evt)
    );

    state_t     state;
    state_t     state_n;
    logic       mid_pend;
    logic       vbl_pend;
    logic       order;       // 1: vblank is the older pending vector
    logic       served_vbl;  // vector frozen at acknowledge
    logic       int_req_r;
    logic [7:0] int_data_r;

    logic       mid_pend_n;
    logic       vbl_pend_n;
    logic       order_n;
    logic       served_vbl_n;
    logic       int_req_n;
    logic [7:0] int_data_n;
    logic [7:0] overrun_n;

    logic       flush;
    logic       serve_done;
    logic       capture;
    logic       head_vbl;
    logic       head_vbl_n;
    logic       other_pend;
    logic       mid_hit;
    logic       vbl_hit;
    logic       mid_new;
    logic       vbl_new;

    assign head_vbl   = vbl_pend & (~mid_pend | order);
    assign other_pend = served_vbl ? mid_pend : vbl_pend;
    assign mid_hit    = mid_evt & irq_en;
    assign vbl_hit    = vbl_evt & irq_en;
    assign mid_new    = mid_hit & ~mid_pend;
    assign vbl_new    = vbl_hit & ~vbl_pend;

    // Sequencer next state: IDLE -> REQ on any pending, REQ -> ACK on inta,
    // ACK exits when inta falls; a disable flushes everything except mid-ACK.
    always_comb begin
        state_n    = state;
        flush      = 1'b0;
        serve_done = 1'b0;
        capture    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!irq_en) begin
                    flush = 1'b1;
                end else if (mid_pend || vbl_pend) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                // The CPU is already fetching once inta is high, so it wins
                // over a same-cycle disable; the flush then happens at ACK exit.
                if (cpu.inta) begin
                    state_n = ST_ACK;
                    capture = 1'b1;
                end else if (!irq_en) begin
                    flush   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!cpu.inta) begin
                    if (!irq_en) begin
                        flush   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        serve_done = 1'b1;
                        state_n    = other_pend ? ST_REQ : ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pending flags, age order and overrun accounting for the next edge
    always_comb begin
        mid_pend_n   = mid_pend;
        vbl_pend_n   = vbl_pend;
        order_n      = order;
        served_vbl_n = capture ? head_vbl : served_vbl;
        overrun_n    = overrun_cnt;

        if (flush || (serve_done && !served_vbl)) begin
            mid_pend_n = 1'b0;
        end
        if (flush || (serve_done && served_vbl)) begin
            vbl_pend_n = 1'b0;
        end
        // A fresh event only sets a flag that is clear; a hit on a set flag
        // (including the one being served) is lost and counted instead.
        if (mid_new) begin
            mid_pend_n = 1'b1;
            order_n    = vbl_pend_n;
        end
        if (vbl_new) begin
            vbl_pend_n = 1'b1;
            order_n    = ~mid_pend_n;
        end
        if ((mid_hit && mid_pend) || (vbl_hit && vbl_pend)) begin
            overrun_n = sat_inc8(overrun_cnt);
        end
    end

    assign head_vbl_n = vbl_pend_n & (~mid_pend_n | order_n);

    // Registered CPU-facing outputs decoded from the next state
    always_comb begin
        int_req_n  = 1'b0;
        int_data_n = NOP_OP;
        unique case (state_n)
            ST_REQ: begin
                int_req_n  = 1'b1;
                int_data_n = head_vbl_n ? VBL_VEC : MID_VEC;
            end
            ST_ACK: begin
                int_data_n = served_vbl_n ? VBL_VEC : MID_VEC;
            end
            default: begin
                int_data_n = NOP_OP;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mid_pend    <= 1'b0;
            vbl_pend    <= 1'b0;
            order       <= 1'b0;
            served_vbl  <= 1'b0;
            int_req_r   <= 1'b0;
            int_data_r  <= NOP_OP;
            overrun_cnt <= 8'd0;
        end else begin
            state       <= state_n;
            mid_pend    <= mid_pend_n;
            vbl_pend    <= vbl_pend_n;
            order       <= order_n;
            served_vbl  <= served_vbl_n;
            int_req_r   <= int_req_n;
            int_data_r  <= int_data_n;
            overrun_cnt <= overrun_n;
        end
    end

    assign cpu.int_req  = int_req_r;
    assign cpu.int_data = int_data_r;

    assign dbg.state        = state;
    assign dbg.inte_blocked = (state == ST_REQ) && !cpu.inte;
    assign dbg.mid_pend     = mid_pend;
    assign dbg.vbl_pend     = vbl_pend;

endmodule
